// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store unit: access-size encodings, the
//   FSM state type, memory geometry and small helpers for size
//   normalisation, alignment checking and lane-offset alignment.
package lsu_pkg;

   localparam int LSU_MEM_DEPTH = 1024;
   localparam int WORD_IDX_W    = $clog2(LSU_MEM_DEPTH);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_MERGE,
      ST_WRITE,
      ST_DONE
   } lsu_state_t;

   // Encoding 11 behaves exactly like a word access.
   function automatic logic [1:0] normSize(input logic [1:0] sz);
      return (sz == 2'b11) ? SZ_WORD : sz;
   endfunction

   // sz must already be normalised.
   function automatic logic isMisaligned(input logic [1:0] sz, input logic [1:0] lo);
      return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
   endfunction

   // Byte offset of the lane actually used, with offending low bits dropped.
   function automatic logic [1:0] alignOffset(input logic [1:0] sz, input logic [1:0] lo);
      logic [1:0] off;
      case (sz)
         SZ_BYTE: off = lo;
         SZ_HALF: off = {lo[1], 1'b0};
         default: off = 2'b00;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/lsu_lane_ops.sv
// lsu_lane_ops
//   Combinational lane logic for the load/store unit.
//   Ports:
//     memWord    in  32  word read from dataMemory
//     newData    in  32  store operand (low byte/half used for sub-word sizes)
//     size       in  2   normalised access size
//     offset     in  2   aligned byte offset of the accessed lane
//     signExt    in  1   sign-extend the extracted lane when set
//     loadValue  out 32  extracted and extended load result
//     mergedWord out 32  memWord with the addressed lane(s) replaced by newData
module lsu_lane_ops
   import lsu_pkg::*;
(
   input  logic [31:0] memWord,
   input  logic [31:0] newData,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        signExt,
   output logic [31:0] loadValue,
   output logic [31:0] mergedWord
);

   logic [31:0] shifted;
   logic [31:0] replicated;
   logic [3:0]  laneEn;

   assign shifted = memWord >> {offset, 3'b000};

   always_comb begin
      case (size)
         SZ_BYTE: loadValue = {{24{signExt & shifted[7]}}, shifted[7:0]};
         SZ_HALF: loadValue = {{16{signExt & shifted[15]}}, shifted[15:0]};
         default: loadValue = memWord;
      endcase
   end

   // Replicating the operand across the word lets each lane pick its byte
   // from the same position it will occupy in memory.
   always_comb begin
      case (size)
         SZ_BYTE: begin
            replicated = {4{newData[7:0]}};
            laneEn     = 4'b0001 << offset;
         end
         SZ_HALF: begin
            replicated = {2{newData[15:0]}};
            laneEn     = 4'b0011 << offset;
         end
         default: begin
            replicated = newData;
            laneEn     = 4'b1111;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign mergedWord[8*gi +: 8] = laneEn[gi] ? replicated[8*gi +: 8] : memWord[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts LDR/STR/LDRB/STRB/LDRH/STRH requests into word-wide cycles on
//   dataMemory (1-cycle registered read, writes whenever readNotWrite=0).
//   Sub-word stores are done as read-modify-write.
//   Build option: define LSU_ALIGN_FAULT_EN to reject misaligned half/word
//   requests with fault=1 and no memory access; otherwise misaligned low
//   address bits are ignored and fault stays 0.
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     start                 request strobe, sampled only in IDLE
//     is_load, size,        request fields, valid in the start cycle
//     sign_ext, addr,
//     store_data
//     busy                  high whenever not IDLE
//     done                  one-cycle completion pulse
//     load_data             registered load result
//     fault                 misalignment flag, valid with done
//     mem_addr              word index to dataMemory
//     mem_din / mem_dout    write data / read data
//     mem_en, mem_rnw       memoryEnable / readNotWrite
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_DEPTH = LSU_MEM_DEPTH,
   parameter int DATA_W    = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_load,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] load_data,
   output logic              fault,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              mem_en,
   output logic              mem_rnw
);

   localparam logic [29:0] IDX_MASK = 30'(MEM_DEPTH - 1);

   lsu_state_t stateReg, stateNext;

   logic              isLoadReg;
   logic [1:0]        sizeReg;
   logic              signExtReg;
   logic [1:0]        offsetReg;
   logic [DATA_W-1:0] storeDataReg;
   logic [DATA_W-1:0] loadDataReg;
   logic [DATA_W-1:0] memDinReg;
   logic [31:0]       memAddrReg;
   logic              faultReg;

   logic [1:0]        reqSize;
   logic              reqFault;
   logic              reqWordStore;
   logic [31:0]       loadValue;
   logic [31:0]       mergedWord;

   assign reqSize      = normSize(size);
   assign reqWordStore = !is_load && (reqSize == SZ_WORD);

`ifdef LSU_ALIGN_FAULT_EN
   assign reqFault = isMisaligned(reqSize, addr[1:0]);
`else
   assign reqFault = 1'b0;
`endif

   lsu_lane_ops u_lane_ops (
      .memWord    (mem_dout),
      .newData    (storeDataReg),
      .size       (sizeReg),
      .offset     (offsetReg),
      .signExt    (signExtReg),
      .loadValue  (loadValue),
      .mergedWord (mergedWord)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= ST_IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      busy      = (stateReg != ST_IDLE);
      done      = (stateReg == ST_DONE);
      mem_en    = 1'b0;
      mem_rnw   = 1'b1;
      case (stateReg)
         ST_IDLE: begin
            if (start) begin
               if (reqFault)          stateNext = ST_DONE;
               else if (reqWordStore) stateNext = ST_WRITE;
               else                   stateNext = ST_READ;
            end
         end
         ST_READ: begin
            mem_en    = 1'b1;
            stateNext = ST_MERGE;
         end
         ST_MERGE: begin
            stateNext = isLoadReg ? ST_DONE : ST_WRITE;
         end
         ST_WRITE: begin
            mem_en    = 1'b1;
            mem_rnw   = 1'b0;
            stateNext = ST_DONE;
         end
         ST_DONE: begin
            stateNext = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
      // The memory writes on any edge with readNotWrite low, so reset must
      // override the WRITE state combinationally to keep the edge harmless.
      if (reset) begin
         mem_en  = 1'b0;
         mem_rnw = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         isLoadReg    <= 1'b0;
         sizeReg      <= SZ_BYTE;
         signExtReg   <= 1'b0;
         offsetReg    <= 2'b00;
         storeDataReg <= '0;
         loadDataReg  <= '0;
         memDinReg    <= '0;
         memAddrReg   <= '0;
         faultReg     <= 1'b0;
      end else begin
         case (stateReg)
            ST_IDLE: begin
               if (start) begin
                  isLoadReg    <= is_load;
                  sizeReg      <= reqSize;
                  signExtReg   <= sign_ext;
                  offsetReg    <= alignOffset(reqSize, addr[1:0]);
                  storeDataReg <= store_data;
                  memAddrReg   <= {2'b00, addr[31:2] & IDX_MASK};
                  faultReg     <= reqFault;
                  // Word stores skip the read, so the write data is ready now.
                  if (reqWordStore) begin
                     memDinReg <= store_data;
                  end
               end
            end
            ST_MERGE: begin
               if (isLoadReg) begin
                  loadDataReg <= loadValue;
               end else begin
                  memDinReg <= mergedWord;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign load_data = loadDataReg;
   assign mem_din   = memDinReg;
   assign mem_addr  = memAddrReg;
   assign fault     = faultReg;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_load;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        mem_en;
   logic        mem_rnw;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_load    (is_load),
      .size       (size),
      .sign_ext   (sign_ext),
      .addr       (addr),
      .store_data (store_data),
      .busy       (busy),
      .done       (done),
      .load_data  (load_data),
      .fault      (fault),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .mem_en     (mem_en),
      .mem_rnw    (mem_rnw)
   );

   // dataMemory model: registered read, write on any edge with rnw low.
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (!mem_rnw) mem[mem_addr[9:0]] <= mem_din;
      if (mem_en)   mem_dout <= mem[mem_addr[9:0]];
   end

   // Running totals of bus activity; tests compare deltas.
   int          totWr = 0;
   int          totEn = 0;
   int          totDone = 0;
   logic [31:0] lastWrIdx = '0;
   logic [31:0] lastWrData = '0;
   always @(negedge clk) begin
      if (!mem_rnw) begin
         totWr      = totWr + 1;
         lastWrIdx  = mem_addr;
         lastWrData = mem_din;
      end
      if (mem_en) totEn = totEn + 1;
      if (done)   totDone = totDone + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // lat = k means done seen in cycle N+k; 0 means no done within the bound.
   task automatic runReq(input logic ld, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic flt);
      @(negedge clk);
      is_load = ld; size = sz; sign_ext = sx; addr = a; store_data = d; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; is_load = 1'b0; size = 2'b00; sign_ext = 1'b0;
      addr = 32'hFFFF_FFFC; store_data = 32'h0;
      lat = 0;
      flt = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            flt = fault;
            break;
         end
      end
      $display("TXN %s size=%0d sx=%0d addr=%h wdata=%h lat=%0d fault=%0d load_data=%h",
               ld ? "LOAD " : "STORE", sz, sx, a, d, lat, flt, load_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic flt;
      int   w0, e0, d0;

      reset = 1'b1; start = 1'b0; is_load = 1'b0; size = 2'b00; sign_ext = 1'b0;
      addr = '0; store_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_fault", 32'(fault), 0);
      chk("reset_load_data", load_data, 0);
      chk("reset_mem_en", 32'(mem_en), 0);
      chk("reset_mem_rnw", 32'(mem_rnw), 1);
      chk("reset_mem_din", mem_din, 0);
      reset = 1'b0;

      // STR then LDR
      w0 = totWr; e0 = totEn;
      runReq(1'b0, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, lat, flt);
      chk("str_lat", lat, 2);
      chk("str_wr_cycles", totWr - w0, 1);
      chk("str_en_cycles", totEn - e0, 1);
      chk("str_wr_idx", lastWrIdx, 32'h10);
      chk("str_wr_data", lastWrData, 32'hDEADBEEF);
      w0 = totWr;
      runReq(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, lat, flt);
      chk("ldr_lat", lat, 3);
      chk("ldr_data", load_data, 32'hDEADBEEF);
      chk("ldr_no_write", totWr - w0, 0);

      // STRB read-modify-write
      runReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h11223344, lat, flt);
      runReq(1'b0, 2'b10, 1'b0, 32'h44, 32'h55555555, lat, flt);
      w0 = totWr; e0 = totEn;
      runReq(1'b0, 2'b00, 1'b0, 32'h42, 32'h123456AA, lat, flt);
      chk("strb_lat", lat, 4);
      chk("strb_wr_cycles", totWr - w0, 1);
      chk("strb_en_cycles", totEn - e0, 2);
      chk("strb_wr_idx", lastWrIdx, 32'h10);
      chk("strb_wr_data", lastWrData, 32'h11AA3344);
      runReq(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, lat, flt);
      chk("strb_readback", load_data, 32'h11AA3344);
      runReq(1'b1, 2'b00, 1'b1, 32'h42, 32'h0, lat, flt);
      chk("ldrsb_data", load_data, 32'hFFFFFFAA);
      runReq(1'b1, 2'b00, 1'b0, 32'h43, 32'h0, lat, flt);
      chk("ldrb_data", load_data, 32'h00000011);

      // Halfword loads and STRH
      runReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h80017FFF, lat, flt);
      runReq(1'b1, 2'b01, 1'b1, 32'h42, 32'h0, lat, flt);
      chk("ldrsh_hi_lat", lat, 3);
      chk("ldrsh_hi_data", load_data, 32'hFFFF8001);
      runReq(1'b1, 2'b01, 1'b0, 32'h40, 32'h0, lat, flt);
      chk("ldrh_lo_data", load_data, 32'h00007FFF);
      runReq(1'b1, 2'b01, 1'b1, 32'h40, 32'h0, lat, flt);
      chk("ldrsh_lo_data", load_data, 32'h00007FFF);
      runReq(1'b0, 2'b01, 1'b0, 32'h42, 32'hCAFE1234, lat, flt);
      chk("strh_lat", lat, 4);
      chk("strh_wr_data", lastWrData, 32'h12347FFF);
      runReq(1'b1, 2'b10, 1'b0, 32'h44, 32'h0, lat, flt);
      chk("neighbour_word", load_data, 32'h55555555);
      runReq(1'b1, 2'b11, 1'b1, 32'h40, 32'h0, lat, flt);
      chk("size11_lat", lat, 3);
      chk("size11_data", load_data, 32'h12347FFF);

      // start held high during a load: only the first request runs
      @(negedge clk);
      d0 = totDone;
      is_load = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h40; start = 1'b1;
      @(posedge clk);
      #1 addr = 32'h44;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done) begin
            start = 1'b0;
            lat = k;
            break;
         end
      end
      start = 1'b0;
      repeat (6) @(negedge clk);
      $display("TXN BUSYDROP lat=%0d done_pulses=%0d load_data=%h", lat, totDone - d0, load_data);
      chk("busy_lat", lat, 3);
      chk("busy_done_pulses", totDone - d0, 1);
      chk("busy_data", load_data, 32'h12347FFF);

      // Reset during the WRITE cycle of STRB
      @(negedge clk);
      is_load = 1'b0; size = 2'b00; addr = 32'h40; store_data = 32'h000000EE; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      chk("prereset_rnw", 32'(mem_rnw), 0);
      reset = 1'b1;
      #1;
      chk("reset_write_rnw", 32'(mem_rnw), 1);
      chk("reset_write_en", 32'(mem_en), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      $display("TXN RESET_IN_WRITE done=%0d busy=%0d", done, busy);
      chk("postreset_done", 32'(done), 0);
      chk("postreset_busy", 32'(busy), 0);
      runReq(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, lat, flt);
      chk("reset_mem_kept", load_data, 32'h12347FFF);

      // Misaligned requests
      runReq(1'b1, 2'b00, 1'b0, 32'h40, 32'h0, lat, flt);
      chk("ldrb_ff", load_data, 32'h000000FF);
      e0 = totEn;
      runReq(1'b1, 2'b10, 1'b0, 32'h41, 32'h0, lat, flt);
`ifdef LSU_ALIGN_FAULT_EN
      chk("mis_ldr_lat", lat, 1);
      chk("mis_ldr_fault", 32'(flt), 1);
      chk("mis_ldr_no_en", totEn - e0, 0);
      chk("mis_ldr_data_kept", load_data, 32'h000000FF);
`else
      chk("mis_ldr_lat", lat, 3);
      chk("mis_ldr_fault", 32'(flt), 0);
      chk("mis_ldr_idx", mem_addr, 32'h10);
      chk("mis_ldr_data", load_data, 32'h12347FFF);
`endif
      w0 = totWr;
      runReq(1'b0, 2'b01, 1'b0, 32'h41, 32'h0000BEEF, lat, flt);
`ifdef LSU_ALIGN_FAULT_EN
      chk("mis_strh_lat", lat, 1);
      chk("mis_strh_fault", 32'(flt), 1);
      chk("mis_strh_no_write", totWr - w0, 0);
`else
      chk("mis_strh_lat", lat, 4);
      chk("mis_strh_fault", 32'(flt), 0);
      chk("mis_strh_wr_data", lastWrData, 32'h1234BEEF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
